// File: rtl/fmac_pkg.sv
// Shared FMAC datapath constants and the multiplier scheduler state type.
package fmac_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        STALL
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping at NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic found;

    // First pass covers [ptr, NREQ-1]; the second pass picks up the wrap into [0, ptr-1].
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (ID_W'(i) >= ptr)) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one external 8x8 multiplier among NREQ requesters.
// Define MULT_RR_SCHED_PRIO_EN to give requester 0 fixed top priority over the rotating rest.
module mult_rr_sched
    import fmac_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OP_W-1:0] req_x,
    input  logic [NREQ*OP_W-1:0] req_y,
    output logic [NREQ-1:0]      req_ready,
    output logic [OP_W-1:0]      mult_x,
    output logic [OP_W-1:0]      mult_y,
    input  logic [PROD_W-1:0]    mult_p,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [PROD_W-1:0]    rsp_data,
    input  logic                 rsp_ready
);

`ifdef MULT_RR_SCHED_PRIO_EN
    localparam logic [ID_W-1:0] PtrRst = ID_W'(1);
`else
    localparam logic [ID_W-1:0] PtrRst = '0;
`endif
    localparam logic [ID_W-1:0] LastId = ID_W'(NREQ - 1);

    sched_state_t       state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               v1_q, v1_d;
    logic [ID_W-1:0]    id1_q, id1_d;
    logic [OP_W-1:0]    mult_x_q, mult_x_d;
    logic [OP_W-1:0]    mult_y_q, mult_y_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [PROD_W-1:0]  rsp_data_q, rsp_data_d;

    logic               adv1, adv2, gnt_any;
    logic [NREQ-1:0]    arb_req, arb_gnt, gnt;
    logic [ID_W-1:0]    arb_gnt_id, gnt_id;
    logic [OP_W-1:0]    sel_x, sel_y;

    assign adv2 = ~rsp_valid_q | rsp_ready;
    assign adv1 = ~v1_q | adv2;

`ifdef MULT_RR_SCHED_PRIO_EN
    assign arb_req = {req_valid[NREQ-1:1], 1'b0};
`else
    assign arb_req = req_valid;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req    (arb_req),
        .ptr    (rr_ptr_q),
        .gnt    (arb_gnt),
        .gnt_id (arb_gnt_id)
    );

    always_comb begin
        gnt    = arb_gnt;
        gnt_id = arb_gnt_id;
`ifdef MULT_RR_SCHED_PRIO_EN
        if (req_valid[0]) begin
            gnt    = NREQ'(1);
            gnt_id = '0;
        end
`endif
        // No grant while held in reset, so nothing is accepted that would be discarded.
        if (!adv1 || !RESET) begin
            gnt = '0;
        end
    end

    assign gnt_any   = |gnt;
    assign req_ready = gnt;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_x = sel_x | req_x[i*OP_W +: OP_W];
                sel_y = sel_y | req_y[i*OP_W +: OP_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        v1_d        = v1_q;
        id1_d       = id1_q;
        mult_x_d    = mult_x_q;
        mult_y_d    = mult_y_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;

        if (adv2) begin
            rsp_valid_d = v1_q;
            rsp_id_d    = id1_q;
            rsp_data_d  = mult_p;
        end

        if (adv1) begin
            v1_d = gnt_any;
            if (gnt_any) begin
                id1_d    = gnt_id;
                mult_x_d = sel_x;
                mult_y_d = sel_y;
`ifdef MULT_RR_SCHED_PRIO_EN
                if (gnt_id != '0) begin
                    rr_ptr_d = (gnt_id == LastId) ? ID_W'(1) : gnt_id + 1'b1;
                end
`else
                rr_ptr_d = (gnt_id == LastId) ? '0 : gnt_id + 1'b1;
`endif
            end
        end

        case (state_q)
            IDLE: begin
                if (gnt_any) state_d = BUSY;
            end
            BUSY: begin
                if (rsp_valid_q && !rsp_ready && v1_q) state_d = STALL;
                else if (!v1_d && !rsp_valid_d)        state_d = IDLE;
            end
            STALL: begin
                if (rsp_ready) state_d = BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PtrRst;
            v1_q        <= 1'b0;
            id1_q       <= '0;
            mult_x_q    <= '0;
            mult_y_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            v1_q        <= v1_d;
            id1_q       <= id1_d;
            mult_x_q    <= mult_x_d;
            mult_y_q    <= mult_y_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign mult_x    = mult_x_q;
    assign mult_y    = mult_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched: directed scenarios plus random traffic against a transaction-queue model.
module tb_mult_rr_sched;
    import fmac_pkg::*;

    localparam int NREQ = 4;
    localparam int ID_W = 3;
`ifdef MULT_RR_SCHED_PRIO_EN
    localparam int PTR0 = 1;
`else
    localparam int PTR0 = 0;
`endif

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*8-1:0]    req_x, req_y;
    logic [NREQ-1:0]      req_ready;
    logic [7:0]           mult_x, mult_y;
    logic [15:0]          mult_p;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_ready;

    logic signed [15:0]   mx_s, my_s;

    // Stand-in for the external multiplier.
    assign mx_s   = {{8{mult_x[7]}}, mult_x};
    assign my_s   = {{8{mult_y[7]}}, mult_y};
    assign mult_p = mx_s * my_s;

    always #5 CLK = ~CLK;

    mult_rr_sched #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .mult_x    (mult_x),
        .mult_y    (mult_y),
        .mult_p    (mult_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
    );

    typedef struct {
        int          id;
        logic [15:0] p;
        int          t;
    } item_t;

    item_t      q[$];
    logic       pend [NREQ];
    logic [7:0] px [NREQ];
    logic [7:0] py [NREQ];
    int         ptr_m = PTR0;
    int         edge_cnt = 0;
    int         last_g = -1;
    bit         started = 0;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec arbitration rule: no grant in reset or with both stages blocked; else first valid from ptr.
    function automatic int pick();
        if (!RESET || (q.size() >= 2 && !rsp_ready)) return -1;
`ifdef MULT_RR_SCHED_PRIO_EN
        if (pend[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++)
            if (pend[1 + (ptr_m - 1 + k) % (NREQ - 1)]) return 1 + (ptr_m - 1 + k) % (NREQ - 1);
`else
        for (int k = 0; k < NREQ; k++)
            if (pend[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]      = pend[i];
            req_x[i*8 +: 8]   = px[i];
            req_y[i*8 +: 8]   = py[i];
        end
    endtask

    task automatic refresh(input int prob);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < prob) begin
                pend[i] = 1'b1;
                px[i]   = 8'($urandom);
                py[i]   = 8'($urandom);
            end
        end
    endtask

    // One clock: check outputs before the edge, advance the model on the edge, return at negedge.
    task automatic cycle();
        int                 g;
        logic               exp_rv;
        item_t              it;
        logic signed [15:0] sx, sy;
        #1;
        g      = pick();
        exp_rv = (q.size() > 0) && (q[0].t + 2 <= edge_cnt);
        if (started) begin
            chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                chk("rsp_data", 32'(rsp_data), 32'(q[0].p));
            end
        end
        @(posedge CLK);
        last_g = g;
        if (!RESET) begin
            q.delete();
            ptr_m = PTR0;
        end else begin
            if (exp_rv && rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                sx   = {{8{px[g][7]}}, px[g]};
                sy   = {{8{py[g][7]}}, py[g]};
                it.id = g;
                it.p  = sx * sy;
                it.t  = edge_cnt;
                q.push_back(it);
                pend[g] = 1'b0;
`ifdef MULT_RR_SCHED_PRIO_EN
                if (g != 0) ptr_m = (g == NREQ - 1) ? 1 : g + 1;
`else
                ptr_m = (g == NREQ - 1) ? 0 : g + 1;
`endif
            end
        end
        edge_cnt++;
        started = 1;
        @(negedge CLK);
    endtask

    initial begin
        logic [7:0]  hold_x;
        logic [15:0] hold_d;
        int          cnt0, cnt1;

        RESET     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            px[i]   = 8'(i + 1);
            py[i]   = 8'(i + 5);
        end
        drive();
        @(negedge CLK);

        // Reset with every requester asserting valid.
        cycle();
        cycle();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mult_x", 32'(mult_x), 32'd0);
        chk("rst_mult_y", 32'(mult_y), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));

        // Single request from requester 2: 7 * -3.
        RESET = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        pend[2] = 1'b1;
        px[2]   = 8'h07;
        py[2]   = 8'hFD;
        drive();
        #1;
        chk("single_grant", 32'(req_ready), 32'h4);
        cycle();
        drive();
        cycle();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd2);
        chk("single_rsp_data", 32'(rsp_data), 32'hFFEB);
        drive();
        cycle();

        // All requesters valid continuously.
        for (int c = 0; c < 12; c++) begin
            refresh(100);
            drive();
            cycle();
        end

        // Back-pressure with both stages full.
        hold_x    = mult_x;
        hold_d    = rsp_data;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            refresh(100);
            drive();
            cycle();
            chk("stall_state", 32'(dut.state_q), 32'(STALL));
            chk("stall_mult_x", 32'(mult_x), 32'(hold_x));
            chk("stall_rsp_data", 32'(rsp_data), 32'(hold_d));
        end
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive();
            cycle();
        end
        chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("drain_state", 32'(dut.state_q), 32'(IDLE));

        // Reset while both stages hold work.
        for (int c = 0; c < 3; c++) begin
            refresh(100);
            drive();
            cycle();
        end
        RESET = 1'b0;
        drive();
        cycle();
        RESET = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        refresh(0);
        pend[1] = 1'b1;
        pend[2] = 1'b1;
        drive();
        #1;
        chk("midrst_grant", 32'(req_ready), 32'h2);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        cycle();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive();
            cycle();
        end

        // Requesters 0 and 1 both continuously valid.
        cnt0 = 0;
        cnt1 = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    pend[i] = 1'b1;
                    px[i]   = 8'($urandom);
                    py[i]   = 8'($urandom);
                end
            end
            drive();
            cycle();
            if (last_g == 0) cnt0++;
            if (last_g == 1) cnt1++;
        end
`ifdef MULT_RR_SCHED_PRIO_EN
        chk("prio_cnt0", 32'(cnt0), 32'd8);
        chk("prio_cnt1", 32'(cnt1), 32'd0);
`else
        chk("alt_cnt0", 32'(cnt0), 32'd4);
        chk("alt_cnt1", 32'(cnt1), 32'd4);
`endif
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

        // Random traffic with random back-pressure and occasional reset.
        for (int c = 0; c < 400; c++) begin
            RESET     = ($urandom_range(0, 199) != 0);
            rsp_ready = ($urandom_range(0, 9) < 7);
            refresh(40);
            drive();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
